// File: rtl/dlx_mem_arb_pkg.sv
// Shared types for the DLX unified-memory arbiter.
//   arb_state_t : arbiter FSM state
//   arb_src_t   : which DLX port owns the current access
package dlx_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Per-access wait timer for the memory arbiter.
// Loadable down-counter preset to TIMEOUT_CYCLES-1. It is loaded every cycle
// the arbiter idles and counts down while an access is outstanding, so
// expired_o rises on the TIMEOUT_CYCLES-th cycle of a grant.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : reload preset
//   run_i         : count down (saturates at zero)
//   expired_o     : counter has reached zero
module arb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PRESET = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = PRESET;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= PRESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Shares one rwmem port between the DLX fetch port (I_*) and load/store
// port (D_*). One access in flight at a time: IDLE picks a winner and
// registers its request, GRANT_x drives MEM_* until MEM_READY (or timeout),
// RESP pulses the winner's READY for one cycle.
//   CLK, RST          : clock, asynchronous active-low reset
//   I_ADDRESS/I_ENABLE -> I_READY/I_DATA          : fetch port
//   D_ADDRESS/D_ENABLE/D_READNOTWRITE/D_WDATA
//                     -> D_READY/D_RDATA          : load/store port
//   MEM_ADDRESS/MEM_ENABLE/MEM_READNOTWRITE/MEM_WDATA/MEM_WDATA_OE,
//   MEM_RDATA/MEM_READY                            : rwmem side
//   ARB_ERR           : sticky access-timeout flag, cleared only by reset
module dlx_mem_arbiter
    import dlx_mem_arb_pkg::*;
#(
    parameter int ADDRESS_SIZE   = 32,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_SIZE-1:0] I_ADDRESS,
    input  logic                    I_ENABLE,
    output logic                    I_READY,
    output logic [WORD_SIZE-1:0]    I_DATA,
    input  logic [ADDRESS_SIZE-1:0] D_ADDRESS,
    input  logic                    D_ENABLE,
    input  logic                    D_READNOTWRITE,
    input  logic [WORD_SIZE-1:0]    D_WDATA,
    output logic                    D_READY,
    output logic [WORD_SIZE-1:0]    D_RDATA,
    output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
    output logic                    MEM_ENABLE,
    output logic                    MEM_READNOTWRITE,
    output logic [WORD_SIZE-1:0]    MEM_WDATA,
    output logic                    MEM_WDATA_OE,
    input  logic [WORD_SIZE-1:0]    MEM_RDATA,
    input  logic                    MEM_READY,
    output logic                    ARB_ERR
);
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    arb_state_t              state_q, state_d;
    arb_src_t                src_q, src_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic                    rnw_q, rnw_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]    idata_q, idata_d;
    logic [WORD_SIZE-1:0]    drdata_q, drdata_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic                    err_q, err_d;

    logic granted;
    logic tmr_expired;

    assign granted = (state_q == GRANT_I) || (state_q == GRANT_D);

    arb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .load_i   (state_q == IDLE),
        .run_i    (granted),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        wdata_d  = wdata_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;
        burst_d  = burst_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                // Fetch wins when alone, or when data has had its full burst
                // while the fetch was kept waiting.
                if (I_ENABLE && (!D_ENABLE || (burst_q == BURST_MAX))) begin
                    state_d = GRANT_I;
                    src_d   = SRC_I;
                    addr_d  = I_ADDRESS;
                    rnw_d   = 1'b1;
                    burst_d = '0;
                end else if (D_ENABLE) begin
                    state_d = GRANT_D;
                    src_d   = SRC_D;
                    addr_d  = D_ADDRESS;
                    rnw_d   = D_READNOTWRITE;
                    wdata_d = D_WDATA;
                    if (!I_ENABLE) begin
                        burst_d = '0;
                    end else if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                // A READY on the expiry cycle still counts as a normal completion.
                if (MEM_READY) begin
                    if (rnw_q) begin
                        if (src_q == SRC_I) begin
                            idata_d = MEM_RDATA;
                        end else begin
                            drdata_d = MEM_RDATA;
                        end
                    end
                    state_d = RESP;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            src_q    <= SRC_I;
            addr_q   <= '0;
            rnw_q    <= 1'b1;
            wdata_q  <= '0;
            idata_q  <= '0;
            drdata_q <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            rnw_q    <= rnw_d;
            wdata_q  <= wdata_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
        end
    end

    // Enables decode straight from the state register so reset drops them
    // asynchronously.
    assign MEM_ENABLE       = granted;
    assign MEM_WDATA_OE     = (state_q == GRANT_D) && !rnw_q;
    assign MEM_ADDRESS      = addr_q;
    assign MEM_READNOTWRITE = rnw_q;
    assign MEM_WDATA        = wdata_q;

    assign I_READY = (state_q == RESP) && (src_q == SRC_I);
    assign D_READY = (state_q == RESP) && (src_q == SRC_D);
    assign I_DATA  = idata_q;
    assign D_RDATA = drdata_q;
    assign ARB_ERR = err_q;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
module tb_dlx_mem_arbiter;
    localparam int TO   = 16;
    localparam int MAXB = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] I_ADDRESS, D_ADDRESS, D_WDATA, I_DATA, D_RDATA;
    logic [31:0] MEM_ADDRESS, MEM_WDATA, MEM_RDATA;
    logic        I_ENABLE, I_READY, D_ENABLE, D_READNOTWRITE, D_READY;
    logic        MEM_ENABLE, MEM_READNOTWRITE, MEM_WDATA_OE, MEM_READY, ARB_ERR;

    always #5 CLK = ~CLK;

    dlx_mem_arbiter #(
        .ADDRESS_SIZE(32), .WORD_SIZE(32), .TIMEOUT_CYCLES(TO), .MAX_DATA_BURST(MAXB)
    ) dut (
        .CLK(CLK), .RST(RST),
        .I_ADDRESS(I_ADDRESS), .I_ENABLE(I_ENABLE), .I_READY(I_READY), .I_DATA(I_DATA),
        .D_ADDRESS(D_ADDRESS), .D_ENABLE(D_ENABLE), .D_READNOTWRITE(D_READNOTWRITE),
        .D_WDATA(D_WDATA), .D_READY(D_READY), .D_RDATA(D_RDATA),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_ENABLE(MEM_ENABLE),
        .MEM_READNOTWRITE(MEM_READNOTWRITE), .MEM_WDATA(MEM_WDATA),
        .MEM_WDATA_OE(MEM_WDATA_OE), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
        .ARB_ERR(ARB_ERR)
    );

    // ---------------- rwmem stand-in ----------------
    int          mem_delay;
    bit          stall;
    bit          force_rdy;
    int          en_cnt_m;
    logic [31:0] ram [64];

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 ^ (32'(i) * 32'h01010101));
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            en_cnt_m <= 0;
        end else begin
            en_cnt_m <= MEM_ENABLE ? en_cnt_m + 1 : 0;
            if (MEM_ENABLE && MEM_READY && !MEM_READNOTWRITE)
                ram[MEM_ADDRESS[7:2]] <= MEM_WDATA;
        end
    end

    assign MEM_READY = force_rdy || (MEM_ENABLE && !stall && (en_cnt_m == mem_delay));
    assign MEM_RDATA = ram[MEM_ADDRESS[7:2]];

    // ---------------- reference model ----------------
    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    dreq_t       dq[$];
    logic [31:0] iq[$];
    logic [31:0] mdl [64];
    int          streak;       // consecutive data grants while a fetch waited
    bit          exp_err;
    logic [31:0] last_i, last_d;
    logic [31:0] order_code;   // one nibble per completion: D=data, 1=fetch
    int          first_lat;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 64; i++) mdl[i] = init_word(i);
        streak  = 0;
        exp_err = 1'b0;
        last_i  = '0;
        last_d  = '0;
    endtask

    task automatic present();
        I_ENABLE = (iq.size() > 0);
        if (iq.size() > 0) I_ADDRESS = iq[0];
        D_ENABLE = (dq.size() > 0);
        if (dq.size() > 0) begin
            D_ADDRESS      = dq[0].addr;
            D_READNOTWRITE = dq[0].rnw;
            D_WDATA        = dq[0].wdata;
        end
    endtask

    // Requesters keep their heads presented back to back; each completion is
    // checked against the policy and the word-level memory model.
    task automatic run_traffic(input int max_cyc);
        int          cyc, en, oe, exp_en;
        bit          both, exp_d;
        dreq_t       r;
        logic [31:0] a, exp_data;
        cyc = 0; en = 0; oe = 0;
        order_code = '0;
        first_lat  = -1;
        present();
        while ((iq.size() > 0 || dq.size() > 0) && cyc < max_cyc) begin
            @(negedge CLK);
            cyc++;
            if (MEM_ENABLE)   en++;
            if (MEM_WDATA_OE) oe++;
            if (I_READY || D_READY) begin
                if (first_lat < 0) first_lat = cyc;
                check("one_ready", 32'(I_READY & D_READY), 32'd0);
                both  = (iq.size() > 0) && (dq.size() > 0);
                exp_d = both ? (streak != MAXB) : (dq.size() > 0);
                check("src_is_d", 32'(D_READY), 32'(exp_d));
                exp_en = stall ? TO : mem_delay + 1;
                check("enable_cycles", en, exp_en);
                check("arb_err", 32'(ARB_ERR), 32'(exp_err));
                if (exp_d) begin
                    r = dq.pop_front();
                    if (r.rnw) begin
                        exp_data = stall ? last_d : mdl[r.addr[7:2]];
                        check("d_rdata", D_RDATA, exp_data);
                        last_d = exp_data;
                    end else begin
                        check("d_rdata_hold", D_RDATA, last_d);
                        if (!stall) mdl[r.addr[7:2]] = r.wdata;
                    end
                    check("oe_cycles", oe, r.rnw ? 0 : exp_en);
                    check("i_data_hold", I_DATA, last_i);
                    streak = (iq.size() > 0) ? streak + 1 : 0;
                    order_code = {order_code[27:0], 4'hD};
                end else begin
                    a = iq.pop_front();
                    exp_data = stall ? last_i : mdl[a[7:2]];
                    check("i_data", I_DATA, exp_data);
                    last_i = exp_data;
                    check("oe_cycles", oe, 0);
                    check("d_rdata_hold", D_RDATA, last_d);
                    streak = 0;
                    order_code = {order_code[27:0], 4'h1};
                end
                en = 0;
                oe = 0;
                present();
            end
        end
        check("traffic_drained", 32'(iq.size() + dq.size()), 32'd0);
        iq.delete();
        dq.delete();
        present();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        I_ENABLE = 1'b0;
        D_ENABLE = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_mem_enable", 32'(MEM_ENABLE), 32'd0);
        check("rst_mem_rnw", 32'(MEM_READNOTWRITE), 32'd1);
        check("rst_mem_oe", 32'(MEM_WDATA_OE), 32'd0);
        check("rst_mem_addr", MEM_ADDRESS, 32'd0);
        check("rst_ready", 32'({I_READY, D_READY}), 32'd0);
        check("rst_i_data", I_DATA, 32'd0);
        check("rst_d_rdata", D_RDATA, 32'd0);
        check("rst_arb_err", 32'(ARB_ERR), 32'd0);
        RST = 1'b1;
        model_init();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        dreq_t r;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WDATA = '0; D_READNOTWRITE = 1'b1;
        I_ENABLE = 1'b0; D_ENABLE = 1'b0;
        mem_delay = 2; stall = 1'b0; force_rdy = 1'b0;
        RST = 1'b0;
        do_reset();

        // 1. lone fetch, 5-cycle latency with DATA_DELAY=2
        iq.push_back(32'h10);
        run_traffic(50);
        check("t1_order", order_code, 32'h1);
        check("t1_data", I_DATA, 32'hDEADBEEF);
        check("t1_latency", 32'(first_lat + 1), 32'd5);

        // 2. simultaneous requests: data first
        iq.push_back(32'h14);
        r.rnw = 1'b1; r.addr = 32'h40; r.wdata = '0; dq.push_back(r);
        run_traffic(50);
        check("t2_order", order_code, 32'hD1);

        // 3. data burst with a waiting fetch
        for (int k = 0; k < 6; k++) begin
            r.rnw = 1'b1; r.addr = 32'h80 + 32'(4 * k); r.wdata = '0; dq.push_back(r);
        end
        iq.push_back(32'h18);
        run_traffic(200);
        check("t3_order", order_code, 32'h0DDDD1DD);

        // 4. store then load
        r.rnw = 1'b0; r.addr = 32'h20; r.wdata = 32'h55; dq.push_back(r);
        r.rnw = 1'b1; r.addr = 32'h20; r.wdata = '0;     dq.push_back(r);
        run_traffic(50);
        check("t4_order", order_code, 32'hDD);
        check("t4_load", D_RDATA, 32'h55);

        // stale MEM_READY while idle is ignored
        force_rdy = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("stale_ready", 32'({I_READY, D_READY, MEM_ENABLE}), 32'd0);
        end
        force_rdy = 1'b0;
        check("stale_i_data", I_DATA, last_i);

        // random mixed traffic
        for (int rnd = 0; rnd < 4; rnd++) begin
            mem_delay = $urandom_range(0, 3);
            for (int k = 0; k < int'($urandom_range(2, 6)); k++)
                iq.push_back(32'($urandom_range(0, 63)) << 2);
            for (int k = 0; k < int'($urandom_range(3, 9)); k++) begin
                r.rnw   = 1'($urandom_range(0, 1));
                r.addr  = 32'($urandom_range(0, 63)) << 2;
                r.wdata = $urandom;
                dq.push_back(r);
            end
            run_traffic(2000);
        end

        // MEM_READY on the expiry cycle completes normally
        mem_delay = TO - 1;
        r.rnw = 1'b1; r.addr = 32'h24; r.wdata = '0; dq.push_back(r);
        iq.push_back(32'h10);
        run_traffic(200);
        check("edge_no_err", 32'(ARB_ERR), 32'd0);

        // 5. timeout: error is sticky, next access still works
        stall = 1'b1;
        exp_err = 1'b1;
        r.rnw = 1'b1; r.addr = 32'h28; r.wdata = '0; dq.push_back(r);
        run_traffic(100);
        stall = 1'b0;
        mem_delay = 2;
        r.rnw = 1'b1; r.addr = 32'h2C; r.wdata = '0; dq.push_back(r);
        iq.push_back(32'h30);
        run_traffic(100);
        check("t5_err_sticky", 32'(ARB_ERR), 32'd1);

        // 6. reset in the middle of a store grant
        mem_delay = 3;
        D_ADDRESS = 32'h34; D_READNOTWRITE = 1'b0; D_WDATA = 32'hAAAA5555; D_ENABLE = 1'b1;
        w = 0;
        while (!MEM_ENABLE && w < 10) begin
            @(negedge CLK);
            w++;
        end
        check("t6_granted", 32'({MEM_ENABLE, MEM_WDATA_OE}), 32'd3);
        #2 RST = 1'b0;
        #1;
        check("t6_async_drop", 32'({MEM_ENABLE, MEM_WDATA_OE}), 32'd0);
        D_ENABLE = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("t6_no_ready", 32'({I_READY, D_READY}), 32'd0);
        end
        RST = 1'b1;
        model_init();
        check("t6_err_cleared", 32'(ARB_ERR), 32'd0);
        iq.push_back(32'h10);
        run_traffic(50);
        check("t6_fetch", I_DATA, 32'hDEADBEEF);
        check("t6_order", order_code, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
